// File: rtl/sc_move_pkg.sv
// Shared types for the Frogger movement controller: FSM state encoding,
// latched move direction and the shift-select command values.
package sc_move_pkg;

  typedef enum logic [3:0] {
    StReset = 4'd0,
    StStart = 4'd1,
    StCheck = 4'd2,
    StUp    = 4'd3,
    StDown  = 4'd4,
    StLeft  = 4'd5,
    StRight = 4'd6,
    StHold  = 4'd7
  } state_e;

  typedef enum logic [2:0] {
    DirNone  = 3'd0,
    DirUp    = 3'd1,
    DirDown  = 3'd2,
    DirLeft  = 3'd3,
    DirRight = 3'd4
  } dir_e;

  localparam logic [1:0] ShiftHold  = 2'b11;
  localparam logic [1:0] ShiftLeft  = 2'b01;
  localparam logic [1:0] ShiftRight = 2'b10;

  // Active-high pressed vector layout: {start, up, down, left, right}.
  localparam int unsigned BtnStart = 4;
  localparam int unsigned BtnUp    = 3;
  localparam int unsigned BtnDown  = 2;
  localparam int unsigned BtnLeft  = 1;
  localparam int unsigned BtnRight = 0;

  // True when the button belonging to a latched direction is still held.
  function automatic logic dir_pressed(dir_e dir, logic [4:0] pressed);
    logic res;
    res = 1'b0;
    case (dir)
      DirUp:    res = pressed[BtnUp];
      DirDown:  res = pressed[BtnDown];
      DirLeft:  res = pressed[BtnLeft];
      DirRight: res = pressed[BtnRight];
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sc_repeattimer.sv
// Hold-to-repeat timer: emits a one-cycle fire pulse after REPEAT_DELAY enabled
// cycles, then every REPEAT_RATE enabled cycles, until cleared.
module sc_repeattimer #(
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 6250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic fire_o
);

  localparam int unsigned MaxCnt = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            first_q, first_d;

  // Count enabled cycles; the first period uses the delay, later ones the rate.
  always_comb begin
    cnt_d   = cnt_q;
    first_d = first_q;
    fire_o  = 1'b0;
    if (clear_i) begin
      cnt_d   = '0;
      first_d = 1'b1;
    end else if (enable_i) begin
      if (cnt_q == (first_q ? DelayLast : RateLast)) begin
        fire_o  = 1'b1;
        cnt_d   = '0;
        first_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/sc_statemachinemove.sv
// Frogger point controller: turns active-low buttons into one-cycle load/shift
// strobes, tracks row/column and blocks moves at the playfield edges.
// Hold-to-repeat stepping is built when SC_STATEMACHINEMOVE_AUTOREPEAT_EN is defined.
module sc_statemachinemove
  import sc_move_pkg::*;
#(
  parameter int unsigned NUM_ROWS     = 8,
  parameter int unsigned NUM_COLS     = 16,
  parameter int unsigned HOME_COL     = 8,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 6250000
) (
  input  logic                        SC_STATEMACHINEMOVE_CLOCK_50,
  input  logic                        SC_STATEMACHINEMOVE_RESET_InLow,
  input  logic                        SC_STATEMACHINEMOVE_startGame_InLow,
  input  logic                        SC_STATEMACHINEMOVE_upButton_InLow,
  input  logic                        SC_STATEMACHINEMOVE_downButton_InLow,
  input  logic                        SC_STATEMACHINEMOVE_leftButton_InLow,
  input  logic                        SC_STATEMACHINEMOVE_rightButton_InLow,
  output logic                        SC_STATEMACHINEMOVE_load0_OutLow,
  output logic                        SC_STATEMACHINEMOVE_load1_OutLow,
  output logic [1:0]                  SC_STATEMACHINEMOVE_shiftselection_Out,
  output logic [$clog2(NUM_ROWS)-1:0] SC_STATEMACHINEMOVE_row_Out,
  output logic [$clog2(NUM_COLS)-1:0] SC_STATEMACHINEMOVE_col_Out,
  output logic                        SC_STATEMACHINEMOVE_atTop_OutHigh
);

  localparam int unsigned RowW = $clog2(NUM_ROWS);
  localparam int unsigned ColW = $clog2(NUM_COLS);
  localparam logic [RowW-1:0] RowMax  = RowW'(NUM_ROWS - 1);
  localparam logic [ColW-1:0] ColMax  = ColW'(NUM_COLS - 1);
  localparam logic [ColW-1:0] ColHome = ColW'(HOME_COL);

  state_e          state_q, state_d;
  dir_e            dir_q, dir_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic [4:0]      pressed;

  assign pressed = ~{SC_STATEMACHINEMOVE_startGame_InLow, SC_STATEMACHINEMOVE_upButton_InLow,
                     SC_STATEMACHINEMOVE_downButton_InLow, SC_STATEMACHINEMOVE_leftButton_InLow,
                     SC_STATEMACHINEMOVE_rightButton_InLow};

`ifdef SC_STATEMACHINEMOVE_AUTOREPEAT_EN
  logic held, fire;

  assign held = dir_pressed(dir_q, pressed);

  // Timer runs only while parked in HOLD; it keeps its phase across repeat moves.
  sc_repeattimer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_repeattimer (
    .clk_i    (SC_STATEMACHINEMOVE_CLOCK_50),
    .rst_ni   (SC_STATEMACHINEMOVE_RESET_InLow),
    .clear_i  (~held),
    .enable_i (held && (state_q == StHold)),
    .fire_o   (fire)
  );
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY, REPEAT_RATE, dir_q};
`endif

  // Next-state, position update and Moore strobe outputs.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    row_d   = row_q;
    col_d   = col_q;
    SC_STATEMACHINEMOVE_load0_OutLow       = 1'b1;
    SC_STATEMACHINEMOVE_load1_OutLow       = 1'b1;
    SC_STATEMACHINEMOVE_shiftselection_Out = ShiftHold;
    unique case (state_q)
      StReset: state_d = StStart;
      StStart: state_d = StCheck;
      StCheck: begin
        dir_d = DirNone;
        if (pressed[BtnStart]) begin
          row_d   = '0;
          col_d   = ColHome;
          state_d = StHold;
        end else if (pressed[BtnUp]) begin
          state_d = StHold;
          if (row_q != RowMax) begin
            state_d = StUp;
            dir_d   = DirUp;
          end
        end else if (pressed[BtnDown]) begin
          state_d = StHold;
          if (row_q != '0) begin
            state_d = StDown;
            dir_d   = DirDown;
          end
        end else if (pressed[BtnLeft]) begin
          state_d = StHold;
          if (col_q != '0) begin
            state_d = StLeft;
            dir_d   = DirLeft;
          end
        end else if (pressed[BtnRight]) begin
          state_d = StHold;
          if (col_q != ColMax) begin
            state_d = StRight;
            dir_d   = DirRight;
          end
        end
      end
      StUp: begin
        SC_STATEMACHINEMOVE_load1_OutLow = 1'b0;
        row_d   = row_q + RowW'(1);
        state_d = StHold;
      end
      StDown: begin
        SC_STATEMACHINEMOVE_load0_OutLow = 1'b0;
        row_d   = row_q - RowW'(1);
        state_d = StHold;
      end
      StLeft: begin
        SC_STATEMACHINEMOVE_shiftselection_Out = ShiftLeft;
        col_d   = col_q - ColW'(1);
        state_d = StHold;
      end
      StRight: begin
        SC_STATEMACHINEMOVE_shiftselection_Out = ShiftRight;
        col_d   = col_q + ColW'(1);
        state_d = StHold;
      end
      StHold: begin
        if (pressed == '0) begin
          state_d = StCheck;
          dir_d   = DirNone;
        end
`ifdef SC_STATEMACHINEMOVE_AUTOREPEAT_EN
        // Releasing the latched button ends repeating until full release.
        else if (!held) begin
          dir_d = DirNone;
        end else if (fire) begin
          case (dir_q)
            DirUp:    if (row_q != RowMax) state_d = StUp;
            DirDown:  if (row_q != '0)     state_d = StDown;
            DirLeft:  if (col_q != '0)     state_d = StLeft;
            DirRight: if (col_q != ColMax) state_d = StRight;
            default:  state_d = StHold;
          endcase
        end
`endif
      end
      default: state_d = StReset;
    endcase
  end

  // State, direction latch and position registers.
  always_ff @(posedge SC_STATEMACHINEMOVE_CLOCK_50 or negedge SC_STATEMACHINEMOVE_RESET_InLow) begin
    if (!SC_STATEMACHINEMOVE_RESET_InLow) begin
      state_q <= StReset;
      dir_q   <= DirNone;
      row_q   <= '0;
      col_q   <= ColHome;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign SC_STATEMACHINEMOVE_row_Out       = row_q;
  assign SC_STATEMACHINEMOVE_col_Out       = col_q;
  assign SC_STATEMACHINEMOVE_atTop_OutHigh = (row_q == RowMax);

endmodule

// File: tb/tb_sc_statemachinemove.sv
// Self-checking bench for sc_statemachinemove: directed vector table, edge and
// reset sequences, hold behaviour and randomized presses against a reference model.
module tb_sc_statemachinemove;

  localparam int unsigned NR = 8;
  localparam int unsigned NC = 16;
  localparam int unsigned HC = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_n, up_n, down_n, left_n, right_n;
  logic       load0_n, load1_n, attop;
  logic [1:0] shsel;
  logic [2:0] row;
  logic [3:0] col;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_statemachinemove #(
    .NUM_ROWS     (NR),
    .NUM_COLS     (NC),
    .HOME_COL     (HC),
    .REPEAT_DELAY (4),
    .REPEAT_RATE  (2)
  ) dut (
    .SC_STATEMACHINEMOVE_CLOCK_50           (clk),
    .SC_STATEMACHINEMOVE_RESET_InLow        (rst_n),
    .SC_STATEMACHINEMOVE_startGame_InLow    (start_n),
    .SC_STATEMACHINEMOVE_upButton_InLow     (up_n),
    .SC_STATEMACHINEMOVE_downButton_InLow   (down_n),
    .SC_STATEMACHINEMOVE_leftButton_InLow   (left_n),
    .SC_STATEMACHINEMOVE_rightButton_InLow  (right_n),
    .SC_STATEMACHINEMOVE_load0_OutLow       (load0_n),
    .SC_STATEMACHINEMOVE_load1_OutLow       (load1_n),
    .SC_STATEMACHINEMOVE_shiftselection_Out (shsel),
    .SC_STATEMACHINEMOVE_row_Out            (row),
    .SC_STATEMACHINEMOVE_col_Out            (col),
    .SC_STATEMACHINEMOVE_atTop_OutHigh      (attop)
  );

  // Pressed vector layout {start, up, down, left, right}, active high.
  localparam logic [4:0] PS = 5'b10000, PU = 5'b01000, PD = 5'b00100;
  localparam logic [4:0] PL = 5'b00010, PR = 5'b00001, P0 = 5'b00000;

  typedef struct {
    logic [4:0] p;
    logic       l0;
    logic       l1;
    logic [1:0] sh;
    int         r;
    int         c;
  } vec_t;

  // Reference model: position plus "booting / deciding / waiting for release"
  // and the command to be shown during the coming cycle.
  int m_row, m_col, m_boot, m_mode, m_pend;

  function automatic logic [11:0] pk(logic l0, logic l1, logic [1:0] sh, int r, int c);
    return {l0, l1, sh, 3'(r), 4'(c), (r == NR - 1)};
  endfunction

  function automatic logic [11:0] obs();
    return {load0_n, load1_n, shsel, row, col, attop};
  endfunction

  function automatic logic [11:0] model_out();
    logic [1:0] sh;
    sh = (m_pend == 3) ? 2'b01 : (m_pend == 4) ? 2'b10 : 2'b11;
    return pk(m_pend != 2, m_pend != 1, sh, m_row, m_col);
  endfunction

  task automatic m_reset();
    m_row = 0; m_col = HC; m_boot = 2; m_mode = 0; m_pend = 0;
  endtask

  task automatic m_step(input logic [4:0] p);
    if (m_pend != 0) begin
      case (m_pend)
        1: m_row++;
        2: m_row--;
        3: m_col--;
        default: m_col++;
      endcase
      m_pend = 0;
      m_mode = 2;
    end else if (m_mode == 0) begin
      m_boot--;
      if (m_boot == 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (p[4]) begin
        m_row = 0; m_col = HC; m_mode = 2;
      end else if (p[3]) begin
        if (m_row < NR - 1) m_pend = 1; else m_mode = 2;
      end else if (p[2]) begin
        if (m_row > 0) m_pend = 2; else m_mode = 2;
      end else if (p[1]) begin
        if (m_col > 0) m_pend = 3; else m_mode = 2;
      end else if (p[0]) begin
        if (m_col < NC - 1) m_pend = 4; else m_mode = 2;
      end
    end else if (p == 5'b0) begin
      m_mode = 1;
    end
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {l0,l1,sh,row,col,top}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic [4:0] p);
    {start_n, up_n, down_n, left_n, right_n} = ~p;
  endtask

  // Drive buttons for one clock edge and return at the following falling edge.
  task automatic tick(input logic [4:0] p);
    apply(p);
    @(posedge clk);
    m_step(p);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(P0);
    #1 check("reset_assert", obs(), pk(1, 1, 2'b11, 0, HC));
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    check("reset_release", obs(), pk(1, 1, 2'b11, 0, HC));
  endtask

  vec_t tbl[21];
  int   nshift;
  logic [4:0] rp;
  int   hold_left;

  initial begin
    tbl[0]  = '{P0,      1, 1, 2'b11, 0, 8};  // START
    tbl[1]  = '{P0,      1, 1, 2'b11, 0, 8};  // CHECK
    tbl[2]  = '{PU,      1, 0, 2'b11, 0, 8};  // UP strobe
    tbl[3]  = '{PU,      1, 1, 2'b11, 1, 8};
    tbl[4]  = '{PU,      1, 1, 2'b11, 1, 8};
    tbl[5]  = '{P0,      1, 1, 2'b11, 1, 8};
    tbl[6]  = '{P0,      1, 1, 2'b11, 1, 8};
    tbl[7]  = '{PD,      0, 1, 2'b11, 1, 8};  // DOWN strobe
    tbl[8]  = '{P0,      1, 1, 2'b11, 0, 8};
    tbl[9]  = '{P0,      1, 1, 2'b11, 0, 8};
    tbl[10] = '{PD,      1, 1, 2'b11, 0, 8};  // blocked at row 0
    tbl[11] = '{P0,      1, 1, 2'b11, 0, 8};
    tbl[12] = '{PU | PL, 1, 0, 2'b11, 0, 8};  // up wins over left
    tbl[13] = '{PL,      1, 1, 2'b11, 1, 8};
    tbl[14] = '{PL,      1, 1, 2'b11, 1, 8};  // left ignored until release
    tbl[15] = '{P0,      1, 1, 2'b11, 1, 8};
    tbl[16] = '{PL,      1, 1, 2'b01, 1, 8};  // LEFT strobe
    tbl[17] = '{P0,      1, 1, 2'b11, 1, 7};
    tbl[18] = '{P0,      1, 1, 2'b11, 1, 7};
    tbl[19] = '{PS,      1, 1, 2'b11, 0, 8};  // start reloads home
    tbl[20] = '{P0,      1, 1, 2'b11, 0, 8};

    rst_n = 1'b0;
    apply(P0);
    m_reset();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 21; i++) begin
      tick(tbl[i].p);
      check($sformatf("vec%0d", i), obs(),
            pk(tbl[i].l0, tbl[i].l1, tbl[i].sh, tbl[i].r, tbl[i].c));
    end

    // Walk to the right edge, then confirm right is blocked there.
    for (int i = 0; i < 7; i++) begin
      tick(PR); tick(P0); tick(P0);
    end
    check("right_edge_col", obs(), pk(1, 1, 2'b11, 0, 15));
    tick(PR);
    check("right_blocked", obs(), pk(1, 1, 2'b11, 0, 15));
    tick(P0);
    // Walk to the top row, then confirm up is blocked there.
    for (int i = 0; i < 7; i++) begin
      tick(PU); tick(P0); tick(P0);
    end
    check("top_row", obs(), pk(1, 1, 2'b11, 7, 15));
    tick(PU);
    check("up_blocked", obs(), pk(1, 1, 2'b11, 7, 15));
    tick(P0);
    tick(PS);
    check("start_from_corner", obs(), pk(1, 1, 2'b11, 0, 8));
    tick(P0);

    // Reset during an UP strobe aborts at once.
    tick(PU); tick(P0); tick(P0);
    tick(PU);
    check("up_strobe_before_reset", obs(), pk(1, 0, 2'b11, 1, 8));
    rst_n = 1'b0;
    #1 check("reset_mid_up", obs(), pk(1, 1, 2'b11, 0, 8));
    apply(P0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    tick(P0);
    check("no_strobe_after_reset", obs(), pk(1, 1, 2'b11, 0, 8));

    // Hold right for 12 cycles from the home column.
    do_reset();
    tick(P0); tick(P0);
    nshift = 0;
    for (int i = 0; i < 15; i++) begin
      tick(i < 12 ? PR : P0);
      if (shsel == 2'b10) nshift++;
    end
`ifdef SC_STATEMACHINEMOVE_AUTOREPEAT_EN
    check_int("repeat_shift_count", nshift, 4);
    check_int("repeat_final_col", int'(col), 12);
`else
    check_int("single_shift_count", nshift, 1);
    check_int("single_final_col", int'(col), 9);
`endif

`ifndef SC_STATEMACHINEMOVE_AUTOREPEAT_EN
    // Randomized presses of varying length against the reference model.
    do_reset();
    hold_left = 0;
    rp = P0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        hold_left = 0;
      end
      if (hold_left == 0) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) begin
          rp = P0;
        end else begin
          rp = 5'b00001 << $urandom_range(0, 4);
          if (rp == PS && $urandom_range(0, 2) != 0) rp = PU;
          if (r == 9) rp = rp | 5'($urandom_range(0, 31));
        end
        hold_left = $urandom_range(1, 4);
      end
      hold_left--;
      tick(rp);
      check($sformatf("rand%0d", i), obs(), model_out());
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
